ram_arbiter: RTL and testbench

- Shares the single-port data RAM between two requesters:
  - port 0: instruction fetch, read-only.
  - port 1: load/store unit, read/write with byte enables.
- Arbitrates round-robin under contention and issues each winning access to the RAM.
- Turns partial-word stores into a two-cycle read-modify-write, because the RAM only writes whole words.
- Returns registered read data with a fixed one-cycle latency.

---
 rtl/ram_arbiter_if.sv | 46 ++++
 rtl/ram_arbiter.sv | 123 ++++++++++++
 tb/tb_ram_arbiter.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_arbiter_if.sv
// Requester and RAM bus bundle for the data-RAM arbiter.
// slave is the arbiter's view; master is the surrounding system's view.
interface ram_arbiter_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    m0_req_i;
  logic [ADDR_WIDTH-1:0]   m0_addr_i;
  logic                    m0_gnt_o;
  logic                    m0_rvalid_o;
  logic [DATA_WIDTH-1:0]   m0_rdata_o;

  logic                    m1_req_i;
  logic                    m1_we_i;
  logic [DATA_WIDTH/8-1:0] m1_be_i;
  logic [ADDR_WIDTH-1:0]   m1_addr_i;
  logic [DATA_WIDTH-1:0]   m1_wdata_i;
  logic                    m1_gnt_o;
  logic                    m1_rvalid_o;
  logic [DATA_WIDTH-1:0]   m1_rdata_o;

  logic                    ram_we_o;
  logic [ADDR_WIDTH-1:0]   ram_addr_o;
  logic [DATA_WIDTH-1:0]   ram_data_o;
  logic [DATA_WIDTH-1:0]   ram_data_i;

  modport slave (
    input  m0_req_i, m0_addr_i,
    input  m1_req_i, m1_we_i, m1_be_i,
    input  m1_addr_i, m1_wdata_i,
    input  ram_data_i,
    output m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    output m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    output ram_we_o, ram_addr_o, ram_data_o
  );

  modport master (
    output m0_req_i, m0_addr_i,
    output m1_req_i, m1_we_i, m1_be_i,
    output m1_addr_i, m1_wdata_i,
    output ram_data_i,
    input  m0_gnt_o, m0_rvalid_o, m0_rdata_o,
    input  m1_gnt_o, m1_rvalid_o, m1_rdata_o,
    input  ram_we_o, ram_addr_o, ram_data_o
  );
endinterface

// File: rtl/ram_arbiter.sv
// Round-robin fetch vs load/store arbiter for a single-port data RAM.
// Partial-word stores are turned into a two-cycle read-modify-write.
module ram_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic         clk_i,
  input  logic         rst_i,
  ram_arbiter_if.slave bus
);
  localparam int BW = DATA_WIDTH / 8;

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t                state, state_n;
  logic                  rr_last;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [DATA_WIDTH-1:0] merge_q, merge_n;
  logic                  rv0, rv1;
  logic [DATA_WIDTH-1:0] rdata0, rdata1;

  logic                  pick0, pick1;
  logic                  gnt0, gnt1;
  logic                  rd0, rd1, latch;
  logic                  we;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wdata;

  always_comb begin
    merge_n = bus.ram_data_i;
    for (int n = 0; n < BW; n++) begin
      if (bus.m1_be_i[n]) begin
        merge_n[8*n +: 8] = bus.m1_wdata_i[8*n +: 8];
      end
    end
  end

  assign pick0 = bus.m0_req_i &
                 (~bus.m1_req_i | rr_last);
  assign pick1 = bus.m1_req_i & ~pick0;

  // Outputs are gated by reset so a write in flight drops at once.
  always_comb begin
    state_n = state;
    gnt0    = 1'b0;
    gnt1    = 1'b0;
    rd0     = 1'b0;
    rd1     = 1'b0;
    latch   = 1'b0;
    we      = 1'b0;
    addr    = '0;
    wdata   = '0;
    if (!rst_i) begin
      unique case (state)
        IDLE: begin
          if (pick0) begin
            addr = bus.m0_addr_i;
            gnt0 = 1'b1;
            rd0  = 1'b1;
          end else if (pick1) begin
            addr = bus.m1_addr_i;
            if (!bus.m1_we_i) begin
              gnt1 = 1'b1;
              rd1  = 1'b1;
            end else if (&bus.m1_be_i) begin
              we    = 1'b1;
              wdata = bus.m1_wdata_i;
              gnt1  = 1'b1;
            end else if (bus.m1_be_i == '0) begin
              gnt1 = 1'b1;
            end else begin
              latch   = 1'b1;
              state_n = RMW_WR;
            end
          end
        end
        RMW_WR: begin
          we      = 1'b1;
          addr    = addr_q;
          wdata   = merge_q;
          gnt1    = 1'b1;
          state_n = IDLE;
        end
        default: state_n = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= IDLE;
      rr_last <= 1'b0;
      addr_q  <= '0;
      merge_q <= '0;
      rv0     <= 1'b0;
      rv1     <= 1'b0;
      rdata0  <= '0;
      rdata1  <= '0;
    end else begin
      state <= state_n;
      rv0   <= rd0;
      rv1   <= rd1;
      if (gnt0) rr_last <= 1'b0;
      else if (gnt1) rr_last <= 1'b1;
      if (latch) begin
        addr_q  <= bus.m1_addr_i;
        merge_q <= merge_n;
      end
      if (rd0) rdata0 <= bus.ram_data_i;
      if (rd1) rdata1 <= bus.ram_data_i;
    end
  end

  assign bus.m0_gnt_o    = gnt0;
  assign bus.m1_gnt_o    = gnt1;
  assign bus.m0_rvalid_o = rv0;
  assign bus.m1_rvalid_o = rv1;
  assign bus.m0_rdata_o  = rdata0;
  assign bus.m1_rdata_o  = rdata1;
  assign bus.ram_we_o    = we;
  assign bus.ram_addr_o  = addr;
  assign bus.ram_data_o  = wdata;
endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: directed scenarios plus random traffic
// checked against a transaction-level model with its own memory image.
module tb_ram_arbiter;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ram_arbiter_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  ram_arbiter #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus.slave)
  );

  logic [31:0] ram [16];
  assign bus.ram_data_i = ram[bus.ram_addr_o[5:2]];
  always @(posedge clk) begin
    if (bus.ram_we_o) ram[bus.ram_addr_o[5:2]] <= bus.ram_data_o;
  end

  int errors = 0;
  int checks = 0;

  logic [31:0] ref_mem [16];
  logic        rr_m;
  bit          busy_m;
  logic [31:0] busy_addr, busy_wdata;
  logic [3:0]  busy_be;
  bit          exp_rv0, exp_rv1;
  logic [31:0] exp_rd0, exp_rd1;
  bit          mg0, mg1;
  logic        obs_g0, obs_g1, obs_we;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] mrg(logic [31:0] old, logic [31:0] wd,
                                      logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int n = 0; n < 4; n++) if (be[n]) r[8*n +: 8] = wd[8*n +: 8];
    return r;
  endfunction

  function automatic int idx(logic [31:0] a);
    return int'(a[5:2]);
  endfunction

  task automatic model_reset();
    rr_m = 1'b0; busy_m = 0;
    exp_rv0 = 0; exp_rv1 = 0;
    exp_rd0 = '0; exp_rd1 = '0;
  endtask

  // Called just after inputs are driven at a negedge; ends at the posedge.
  task automatic step();
    bit g0, g1, we, rd0, rd1, rmw, w0, w1;
    logic [31:0] a, d;
    #1;
    g0 = 0; g1 = 0; we = 0; rd0 = 0; rd1 = 0; rmw = 0;
    a = '0; d = '0;
    if (rst) begin
      model_reset();
    end else if (busy_m) begin
      g1 = 1; we = 1; a = busy_addr;
      d = mrg(ref_mem[idx(busy_addr)], busy_wdata, busy_be);
    end else begin
      w0 = bus.m0_req_i && (!bus.m1_req_i || rr_m);
      w1 = bus.m1_req_i && !w0;
      if (w0) begin
        g0 = 1; rd0 = 1; a = bus.m0_addr_i;
      end else if (w1) begin
        a = bus.m1_addr_i;
        if (!bus.m1_we_i) begin g1 = 1; rd1 = 1; end
        else if (bus.m1_be_i == 4'hF) begin
          g1 = 1; we = 1; d = bus.m1_wdata_i;
        end else if (bus.m1_be_i == 4'h0) g1 = 1;
        else begin
          rmw = 1; busy_wdata = bus.m1_wdata_i; busy_be = bus.m1_be_i;
        end
      end
    end
    obs_g0 = bus.m0_gnt_o; obs_g1 = bus.m1_gnt_o; obs_we = bus.ram_we_o;
    chk("m0_gnt", bus.m0_gnt_o, g0);
    chk("m1_gnt", bus.m1_gnt_o, g1);
    chk("ram_we", bus.ram_we_o, we);
    chk("ram_addr", bus.ram_addr_o, a);
    chk("ram_data", bus.ram_data_o, d);
    chk("m0_rvalid", bus.m0_rvalid_o, exp_rv0);
    chk("m1_rvalid", bus.m1_rvalid_o, exp_rv1);
    chk("m0_rdata", bus.m0_rdata_o, exp_rd0);
    chk("m1_rdata", bus.m1_rdata_o, exp_rd1);
    mg0 = g0; mg1 = g1;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      exp_rv0 = rd0; exp_rv1 = rd1;
      if (rd0) exp_rd0 = ref_mem[idx(a)];
      if (rd1) exp_rd1 = ref_mem[idx(a)];
      if (g0) rr_m = 1'b0;
      if (g1) rr_m = 1'b1;
      if (we) ref_mem[idx(a)] = d;
      if (busy_m) busy_m = 0;
      if (rmw) begin busy_m = 1; busy_addr = a; end
    end
  endtask

  task automatic idle_in();
    bus.m0_req_i = 0; bus.m0_addr_i = '0;
    bus.m1_req_i = 0; bus.m1_we_i = 0; bus.m1_be_i = '0;
    bus.m1_addr_i = '0; bus.m1_wdata_i = '0;
  endtask

  task automatic m1_set(logic we, logic [3:0] be, logic [31:0] a,
                        logic [31:0] wd);
    bus.m1_req_i = 1; bus.m1_we_i = we; bus.m1_be_i = be;
    bus.m1_addr_i = a; bus.m1_wdata_i = wd;
  endtask

  bit p0, p1;
  int sel;

  initial begin
    rst = 1'b1;
    idle_in();
    for (int i = 0; i < 16; i++) ram[i] = 32'h01010101 * i;
    ram[1] = 32'hDEADBEEF;
    for (int i = 0; i < 16; i++) ref_mem[i] = ram[i];
    model_reset();

    @(negedge clk); step();
    @(negedge clk); step();
    @(negedge clk); rst = 1'b0; step();

    // Single fetch of word 1
    @(negedge clk); bus.m0_req_i = 1; bus.m0_addr_i = 32'h4; step();
    chk("t1_gnt", obs_g0, 1'b1);
    #1;
    chk("t1_rvalid", bus.m0_rvalid_o, 1'b1);
    chk("t1_rdata", bus.m0_rdata_o, 32'hDEADBEEF);
    @(negedge clk); idle_in(); step();

    // Continuous contention alternates, m1 first
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.m0_req_i = 1; bus.m0_addr_i = 32'h0;
      m1_set(0, 4'h0, 32'h8, 32'h0);
      step();
      chk("t2_alt", obs_g1, (i % 2 == 0));
    end
    @(negedge clk); idle_in(); step();

    // Full store then load back
    @(negedge clk); m1_set(1, 4'hF, 32'hC, 32'h12345678); step();
    chk("t3_gnt", obs_g1, 1'b1);
    chk("t3_we", obs_we, 1'b1);
    @(negedge clk); m1_set(0, 4'h0, 32'hC, 32'h0); step();
    #1;
    chk("t3_rdata", bus.m1_rdata_o, 32'h12345678);

    // Partial store with m0 joining in the write cycle
    @(negedge clk); m1_set(1, 4'b0010, 32'hC, 32'h0000AB00); step();
    chk("t4_c1_gnt", obs_g1, 1'b0);
    chk("t4_c1_we", obs_we, 1'b0);
    @(negedge clk); bus.m0_req_i = 1; bus.m0_addr_i = 32'h0; step();
    chk("t4_c2_gnt", obs_g1, 1'b1);
    chk("t4_c2_we", obs_we, 1'b1);
    chk("t4_c2_m0", obs_g0, 1'b0);
    #1;
    chk("t4_word", ram[3], 32'h1234AB78);
    @(negedge clk); bus.m1_req_i = 0; step();
    chk("t4_c3_m0", obs_g0, 1'b1);
    @(negedge clk); idle_in(); step();

    // Store with no byte enables
    @(negedge clk); m1_set(1, 4'h0, 32'h10, 32'hFFFFFFFF); step();
    chk("t5_gnt", obs_g1, 1'b1);
    chk("t5_we", obs_we, 1'b0);
    @(negedge clk); idle_in(); step();
    chk("t5_word", ram[4], 32'h04040404);

    // Reset lands in the write cycle of a partial store
    @(negedge clk); m1_set(1, 4'b0001, 32'h14, 32'h000000FF); step();
    @(negedge clk); rst = 1'b1; step();
    chk("t6_we", obs_we, 1'b0);
    #1;
    chk("t6_word", ram[5], 32'h05050505);
    @(negedge clk); idle_in(); rst = 1'b0; step();
    @(negedge clk);
    bus.m0_req_i = 1; bus.m0_addr_i = 32'h0;
    m1_set(0, 4'h0, 32'h8, 32'h0);
    step();
    chk("t6_first", obs_g1, 1'b1);
    @(negedge clk); idle_in(); step();

    // Random traffic obeying the hold-until-grant protocol
    p0 = 0; p1 = 0;
    for (int c = 0; c < 2000; c++) begin
      @(negedge clk);
      if (!p0 && $urandom_range(0, 1) == 1) begin
        p0 = 1; bus.m0_addr_i = $urandom_range(0, 63);
      end
      bus.m0_req_i = p0;
      if (!p1 && $urandom_range(0, 1) == 1) begin
        p1 = 1;
        bus.m1_we_i = $urandom_range(0, 1) == 1;
        sel = $urandom_range(0, 3);
        bus.m1_be_i = (sel == 0) ? 4'hF : (sel == 1) ? 4'h0
                                        : 4'($urandom_range(0, 15));
        bus.m1_addr_i = $urandom_range(0, 63);
        bus.m1_wdata_i = $urandom;
      end
      bus.m1_req_i = p1;
      step();
      if (mg0) p0 = 0;
      if (mg1) p1 = 0;
    end
    @(negedge clk); idle_in(); step();
    @(negedge clk); step();
    for (int i = 0; i < 16; i++) chk("final_mem", ram[i], ref_mem[i]);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
